bcd_serial_subtractor: RTL and testbench
========================================

# bcd_serial_subtractor

Digit-serial, multi-digit packed-BCD subtractor computing |A − B| with a sign flag, one BCD digit per clock, least-significant digit first. It is the subtraction counterpart of the team's combinational single-digit BCD adder. It is intended for the calculator datapath, where operands arrive as packed BCD words and a start/done handshake is used instead of a deep combinational chain.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits per operand; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a` input 4*DIGITS: minuend, packed BCD, digit 0 = `a[3:0]`.
- `b` input 4*DIGITS: subtrahend, packed BCD.
- `busy` output 1: high in SUB, CORR, DONE.
- `done` output 1: one-cycle pulse in DONE.
- `diff` output 4*DIGITS: magnitude |A − B| in packed BCD; held until next accepted start.
- `negative` output 1: 1 when A < B; held like `diff`.
- `invalid` output 1: 1 when any nibble of `a` or `b` is > 9 at start; held like `diff`.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `negative`=0, `invalid`=0, digit index=0, borrow=0.
- **States:** IDLE, SUB, CORR, DONE.
- **IDLE:** `start`=1 is accepted.
  - Latch `a`/`b` into operand registers.
  - Clear `diff`, `negative` and borrow; set index=0.
  - If any input nibble is > 9, set `invalid`=1 and go to DONE.
  - Otherwise clear `invalid` and go to SUB.
- **SUB:** each cycle, digit index i is processed.
  - t = a_i − b_i − borrow, computed 5-bit signed.
  - If t < 0: digit = t + 10, borrow_out = 1; else digit = t, borrow_out = 0.
  - Write the digit into `diff[4i+3:4i]`; index increments.
  - After digit DIGITS−1: if final borrow = 0 go to DONE; else go to CORR with index=0 and borrow=0. The raw result is then the ten's complement.
- **CORR:** each cycle, digit i of `diff` is replaced by (0 − diff_i − borrow) using the same digit rule.
  - After the last digit, set `negative`=1, discard the final borrow, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. Outputs are stable throughout DONE and after it.
- `start` asserted outside IDLE is ignored; it is not queued.
- Operand registers do not track `a`/`b` after acceptance.
- Equal operands give `diff`=0, `negative`=0; there is no negative zero.
- Reset asserted in any state returns to reset values on that edge. A partial result is never flagged done.

## Timing
- Start accepted at edge 0 (start high in cycle 0).
  - Valid, A ≥ B: SUB in cycles 1..DIGITS; `done` in cycle DIGITS+1.
  - Valid, A < B: CORR in cycles DIGITS+1..2·DIGITS; `done` in cycle 2·DIGITS+1.
  - Invalid: `done` in cycle 1.
- Back-to-back: a new start is accepted at the earliest in the cycle after DONE (IDLE).
- No combinational path from inputs to outputs.

## Structure
- Package `bcd_pkg` holds:
  - `DIGIT_W`=4, `BCD_TEN`=4'd10, `BCD_MAX`=4'd9;
  - the state enum/localparams IDLE/SUB/CORR/DONE.
- One combinational sub-module `bcd_digit_sub`.
  - Ports: `x[3:0]`, `y[3:0]`, `bin` → `d[3:0]`, `bout`.
  - Instantiated once and shared by SUB (x=a_i, y=b_i) and CORR (x=0, y=diff_i).
- Top level contains the FSM, index counter, borrow flop, operand/result registers, and the validity check.

## Test plan
With DIGITS=4:
- `a`=0x1234, `b`=0x0567, start pulse → `done` in cycle 5, `diff`=0x0667, `negative`=0, `invalid`=0.
- `a`=0x0005, `b`=0x0012 → `done` in cycle 9, `diff`=0x0007, `negative`=1.
- `a`=0x0100, `b`=0x0001 → `diff`=0x0099 (borrow ripple across two digits); `a`=0x9999, `b`=0x9999 → `diff`=0x0000, `negative`=0.
- `a`=0x12A4, `b`=0x0001 → `done` in cycle 1, `invalid`=1, `diff`=0x0000; next valid op clears `invalid`.
- Start 0x5000−0x0001, pulse `start` again with 0x1111−0x1111 in cycle 2 → second request ignored, `diff`=0x4999. Back-to-back start in the cycle after `done` is accepted.
- Assert `rst` in cycle 3 of an operation → next cycle all outputs 0, state IDLE, no `done` pulse; a following operation completes correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD subtractor.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  BCD_TEN = 4'd10;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSub  = 2'd1,
        StCorr = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract with borrow: d = x - y - bin, wrapped into 0..9.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [4:0] t;

    always_comb begin
        t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
        // Sign bit of the 5-bit difference is the borrow; add ten to fold back.
        bout = t[4];
        d    = bout ? (t[3:0] + BCD_TEN) : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD |A - B| with sign flag; one digit per clock, LSD first,
// followed by a ten's-complement correction pass when A < B.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] diff,
    output logic                      negative,
    output logic                      invalid
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

    state_e                    state_q;
    logic [IdxW-1:0]           idx_q;
    logic                      borrow_q;
    logic [DIGIT_W*DIGITS-1:0] a_q;
    logic [DIGIT_W*DIGITS-1:0] b_q;
    logic [DIGIT_W*DIGITS-1:0] diff_q;
    logic                      negative_q;
    logic                      invalid_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      in_bad;
    logic [3:0]                sub_x;
    logic [3:0]                sub_y;
    logic [3:0]                sub_d;
    logic                      sub_bout;

    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a[DIGIT_W*i +: DIGIT_W] > BCD_MAX || b[DIGIT_W*i +: DIGIT_W] > BCD_MAX) begin
                in_bad = 1'b1;
            end
        end
    end

    // One digit slice shared by both passes; CORR computes 0 - diff_i - borrow.
    always_comb begin
        if (state_q == StCorr) begin
            sub_x = 4'd0;
            sub_y = diff_q[DIGIT_W*idx_q +: DIGIT_W];
        end else begin
            sub_x = a_q[DIGIT_W*idx_q +: DIGIT_W];
            sub_y = b_q[DIGIT_W*idx_q +: DIGIT_W];
        end
    end

    bcd_digit_sub u_digit (
        .x    (sub_x),
        .y    (sub_y),
        .bin  (borrow_q),
        .d    (sub_d),
        .bout (sub_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            negative_q <= 1'b0;
            invalid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q        <= a;
                        b_q        <= b;
                        diff_q     <= '0;
                        negative_q <= 1'b0;
                        borrow_q   <= 1'b0;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        if (in_bad) begin
                            invalid_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            invalid_q <= 1'b0;
                            state_q   <= StSub;
                        end
                    end
                end
                StSub: begin
                    diff_q[DIGIT_W*idx_q +: DIGIT_W] <= sub_d;
                    if (idx_q == IdxLast) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        if (sub_bout) begin
                            state_q <= StCorr;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        borrow_q <= sub_bout;
                    end
                end
                StCorr: begin
                    diff_q[DIGIT_W*idx_q +: DIGIT_W] <= sub_d;
                    if (idx_q == IdxLast) begin
                        idx_q      <= '0;
                        borrow_q   <= 1'b0;
                        negative_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        borrow_q <= sub_bout;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign negative = negative_q;
    assign invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4) against an integer model.
module tb_bcd_serial_subtractor;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4*D-1:0] a = '0;
    logic [4*D-1:0] b = '0;
    logic          busy;
    logic          done;
    logic [4*D-1:0] diff;
    logic          negative;
    logic          invalid;

    int checks = 0;
    int errors = 0;

    bcd_serial_subtractor #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .negative (negative),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    function automatic int bcd_val(input logic [4*D-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < D; i++) begin
            r += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t /= 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [4*D-1:0] x, input logic [4*D-1:0] y);
        for (int i = 0; i < D; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Starts an op (start high for one cycle = cycle 0), returns the cycle in which done was
    // seen (-1 if none), the outputs at that point, and the done level one cycle later (IDLE).
    task automatic do_op(input logic [4*D-1:0] av, input logic [4*D-1:0] bv, output int lat,
                         output logic [4*D-1:0] d, output logic n, output logic iv,
                         output logic done_after, output logic busy_after);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        d = diff; n = negative; iv = invalid;
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, negative, invalid, diff} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b neg=%b inv=%b diff=%h exp all 0",
                     busy, done, negative, invalid, diff);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [4*D-1:0] ta[5] = '{16'h1234, 16'h0005, 16'h0100, 16'h9999, 16'h12A4};
        logic [4*D-1:0] tb[5] = '{16'h0567, 16'h0012, 16'h0001, 16'h9999, 16'h0001};
        logic [4*D-1:0] td[5] = '{16'h0667, 16'h0007, 16'h0099, 16'h0000, 16'h0000};
        logic           tn[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic           ti[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int             tl[5] = '{5, 9, 5, 5, 1};
        int lat;
        logic [4*D-1:0] d;
        logic n, iv, da, ba;
        for (int k = 0; k < 5; k++) begin
            do_op(ta[k], tb[k], lat, d, n, iv, da, ba);
            checks++;
            if (lat !== tl[k] || d !== td[k] || n !== tn[k] || iv !== ti[k]) begin
                errors++;
                $display("FAIL directed_%0d got lat=%0d diff=%h neg=%b inv=%b exp lat=%0d diff=%h neg=%b inv=%b",
                         k, lat, d, n, iv, tl[k], td[k], tn[k], ti[k]);
            end
        end
        // Valid op right after the invalid one must clear the flag.
        do_op(16'h0042, 16'h0040, lat, d, n, iv, da, ba);
        checks++;
        if (iv !== 1'b0 || d !== 16'h0002 || lat !== 5) begin
            errors++;
            $display("FAIL invalid_clear got inv=%b diff=%h lat=%0d exp inv=0 diff=0002 lat=5",
                     iv, d, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        @(negedge clk);
        a = 16'h5000; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;                 // cycle 1
        start = 1'b0;
        @(posedge clk); #1;                 // cycle 2
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1;                 // cycle 3
        start = 1'b0;
        for (int c = 3; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat !== 5 || diff !== 16'h4999 || negative !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d diff=%h neg=%b exp lat=5 diff=4999 neg=0",
                     lat, diff, negative);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [4*D-1:0] d;
        logic n, iv, da, ba;
        // do_op returns in the IDLE cycle, so the next call raises start right there.
        do_op(16'h0300, 16'h0450, lat, d, n, iv, da, ba);
        do_op(16'h0777, 16'h0111, lat, d, n, iv, da, ba);
        checks++;
        if (lat !== 5 || d !== 16'h0666 || n !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back got lat=%0d diff=%h neg=%b exp lat=5 diff=0666 neg=0",
                     lat, d, n);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [4*D-1:0] d;
        logic n, iv, da, ba;
        logic saw_done = 1'b0;
        @(negedge clk);
        a = 16'h0005; b = 16'h0012; start = 1'b1;
        @(posedge clk); #1;                 // cycle 1
        start = 1'b0;
        saw_done |= done;
        @(posedge clk); #1;                 // cycle 2
        saw_done |= done;
        @(posedge clk); #1;                 // cycle 3
        saw_done |= done;
        rst = 1'b1;
        @(posedge clk); #1;                 // cycle 4
        rst = 1'b0;
        checks++;
        if ({busy, done, negative, invalid, diff} !== '0 || saw_done) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b neg=%b inv=%b diff=%h saw_done=%b exp all 0",
                     busy, done, negative, invalid, diff, saw_done);
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            saw_done |= done;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got done pulse after reset exp none");
        end
        do_op(16'h2000, 16'h0001, lat, d, n, iv, da, ba);
        checks++;
        if (lat !== 5 || d !== 16'h1999 || n !== 1'b0 || iv !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got lat=%0d diff=%h neg=%b inv=%b exp lat=5 diff=1999 neg=0 inv=0",
                     lat, d, n, iv);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [4*D-1:0] d, av, bv, ed;
        logic n, iv, da, ba, en, ei;
        int el, va, vb;
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < D; i++) begin
                av[4*i +: 4] = 4'($urandom_range(0, 9));
                bv[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) av[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) bv = av;
            if (has_bad(av, bv)) begin
                ed = '0; en = 1'b0; ei = 1'b1; el = 1;
            end else begin
                va = bcd_val(av);
                vb = bcd_val(bv);
                en = (va < vb);
                ed = to_bcd(en ? vb - va : va - vb);
                ei = 1'b0;
                el = en ? 2*D + 1 : D + 1;
            end
            do_op(av, bv, lat, d, n, iv, da, ba);
            checks++;
            if (lat !== el || d !== ed || n !== en || iv !== ei) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h got lat=%0d diff=%h neg=%b inv=%b exp lat=%0d diff=%h neg=%b inv=%b",
                         k, av, bv, lat, d, n, iv, el, ed, en, ei);
            end
            checks++;
            if (da !== 1'b0 || ba !== 1'b0 || diff !== ed) begin
                errors++;
                $display("FAIL random_hold_%0d got done=%b busy=%b diff=%h exp done=0 busy=0 diff=%h",
                         k, da, ba, diff, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
